// File: rtl/alu_issue_queue_pkg.sv
// rtl/alu_issue_queue_pkg.sv - shared sizing and constants for the ALU issue queue
package alu_issue_queue_pkg;

    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 6;
    localparam int IDX_W   = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    localparam logic              TRUE      = 1'b1;
    localparam logic              FALSE     = 1'b0;
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;

endpackage

// File: rtl/alu_issue_queue_prio_sel.sv
// rtl/alu_issue_queue_prio_sel.sv - lowest-index fixed-priority selector
module prio_sel #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // scan upward; the first set request wins and blocks later ones
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - reservation station and issue scheduler for the integer ALU
module alu_issue_queue
    import alu_issue_queue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              has_misbranch,
    input  logic              dispatch_valid,
    input  logic [OP_W-1:0]   dispatch_op,
    input  logic [DATA_W-1:0] dispatch_imm,
    input  logic [31:0]       dispatch_pc,
    input  logic [4:0]        dispatch_shamt,
    input  logic [ROB_W-1:0]  dispatch_rd_robnum,
    input  logic              dispatch_rs1_ready,
    input  logic              dispatch_rs2_ready,
    input  logic [DATA_W-1:0] dispatch_rs1_val,
    input  logic [DATA_W-1:0] dispatch_rs2_val,
    input  logic [ROB_W-1:0]  dispatch_rs1_tag,
    input  logic [ROB_W-1:0]  dispatch_rs2_tag,
    output logic              rs_full,
    input  logic              cdb_alu_valid,
    input  logic              cdb_lsb_valid,
    input  logic [ROB_W-1:0]  cdb_alu_robnum,
    input  logic [ROB_W-1:0]  cdb_lsb_robnum,
    input  logic [DATA_W-1:0] cdb_alu_data,
    input  logic [DATA_W-1:0] cdb_lsb_data,
    output logic              has_to_alu,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_imm,
    output logic [31:0]       alu_pc,
    output logic [4:0]        alu_shamt,
    output logic [ROB_W-1:0]  alu_rd_robnum,
    output logic [DATA_W-1:0] alu_rs1_oprand,
    output logic [DATA_W-1:0] alu_rs2_oprand
);

    logic [RS_SIZE-1:0] valid;
    logic [OP_W-1:0]    e_op    [RS_SIZE];
    logic [DATA_W-1:0]  e_imm   [RS_SIZE];
    logic [31:0]        e_pc    [RS_SIZE];
    logic [4:0]         e_shamt [RS_SIZE];
    logic [ROB_W-1:0]   e_rd    [RS_SIZE];
    logic [RS_SIZE-1:0] e_rs1_rdy;
    logic [RS_SIZE-1:0] e_rs2_rdy;
    logic [DATA_W-1:0]  e_rs1_val [RS_SIZE];
    logic [DATA_W-1:0]  e_rs2_val [RS_SIZE];
    logic [ROB_W-1:0]   e_rs1_tag [RS_SIZE];
    logic [ROB_W-1:0]   e_rs2_tag [RS_SIZE];

    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] issue_grant;
    logic [IDX_W-1:0]   issue_idx;
    logic               issue_any;
    logic [RS_SIZE-1:0] free_grant;
    logic [IDX_W-1:0]   free_idx;
    logic               free_any;
    logic               do_dispatch;

    logic [RS_SIZE-1:0] wake_rs1_rdy;
    logic [RS_SIZE-1:0] wake_rs2_rdy;
    logic [DATA_W-1:0]  wake_rs1_val [RS_SIZE];
    logic [DATA_W-1:0]  wake_rs2_val [RS_SIZE];
    logic               disp_rs1_rdy;
    logic               disp_rs2_rdy;
    logic [DATA_W-1:0]  disp_rs1_val;
    logic [DATA_W-1:0]  disp_rs2_val;

    // an operand that is still waiting takes the broadcast value on a tag hit; ALU bus first
    function automatic logic [DATA_W:0] resolve(
        input logic              op_ready,
        input logic [DATA_W-1:0] op_val,
        input logic [ROB_W-1:0]  op_tag
    );
        if (op_ready)
            return {TRUE, op_val};
        else if (cdb_alu_valid && cdb_alu_robnum == op_tag)
            return {TRUE, cdb_alu_data};
        else if (cdb_lsb_valid && cdb_lsb_robnum == op_tag)
            return {TRUE, cdb_lsb_data};
        else
            return {FALSE, op_val};
    endfunction

    assign rs_full     = &valid;
    assign ready_vec   = valid & e_rs1_rdy & e_rs2_rdy;
    assign do_dispatch = dispatch_valid && free_any;

    prio_sel #(.N(RS_SIZE), .IDX_W(IDX_W)) u_issue_sel (
        .req   (ready_vec),
        .grant (issue_grant),
        .idx   (issue_idx),
        .any   (issue_any)
    );

    prio_sel #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .req   (~valid),
        .grant (free_grant),
        .idx   (free_idx),
        .any   (free_any)
    );

    // operand values each entry and the incoming op would hold after this edge's broadcasts
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            {wake_rs1_rdy[i], wake_rs1_val[i]} = resolve(e_rs1_rdy[i], e_rs1_val[i], e_rs1_tag[i]);
            {wake_rs2_rdy[i], wake_rs2_val[i]} = resolve(e_rs2_rdy[i], e_rs2_val[i], e_rs2_tag[i]);
        end
        {disp_rs1_rdy, disp_rs1_val} = resolve(dispatch_rs1_ready, dispatch_rs1_val, dispatch_rs1_tag);
        {disp_rs2_rdy, disp_rs2_val} = resolve(dispatch_rs2_ready, dispatch_rs2_val, dispatch_rs2_tag);
    end

    // queue state and issue register: flush beats issue, wakeup and dispatch; rdy low freezes all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid          <= '0;
            e_rs1_rdy      <= '0;
            e_rs2_rdy      <= '0;
            has_to_alu     <= FALSE;
            alu_op         <= '0;
            alu_imm        <= ZERO_DATA;
            alu_pc         <= '0;
            alu_shamt      <= '0;
            alu_rd_robnum  <= '0;
            alu_rs1_oprand <= ZERO_DATA;
            alu_rs2_oprand <= ZERO_DATA;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_op[i]      <= '0;
                e_imm[i]     <= ZERO_DATA;
                e_pc[i]      <= '0;
                e_shamt[i]   <= '0;
                e_rd[i]      <= '0;
                e_rs1_val[i] <= ZERO_DATA;
                e_rs2_val[i] <= ZERO_DATA;
                e_rs1_tag[i] <= '0;
                e_rs2_tag[i] <= '0;
            end
        end else if (rdy) begin
            if (has_misbranch) begin
                valid      <= '0;
                has_to_alu <= FALSE;
            end else begin
                valid      <= (valid & ~issue_grant) | (do_dispatch ? free_grant : '0);
                has_to_alu <= issue_any;
                if (issue_any) begin
                    alu_op         <= e_op[issue_idx];
                    alu_imm        <= e_imm[issue_idx];
                    alu_pc         <= e_pc[issue_idx];
                    alu_shamt      <= e_shamt[issue_idx];
                    alu_rd_robnum  <= e_rd[issue_idx];
                    alu_rs1_oprand <= e_rs1_val[issue_idx];
                    alu_rs2_oprand <= e_rs2_val[issue_idx];
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid[i]) begin
                        e_rs1_rdy[i] <= wake_rs1_rdy[i];
                        e_rs1_val[i] <= wake_rs1_val[i];
                        e_rs2_rdy[i] <= wake_rs2_rdy[i];
                        e_rs2_val[i] <= wake_rs2_val[i];
                    end
                end
                if (do_dispatch) begin
                    e_op[free_idx]      <= dispatch_op;
                    e_imm[free_idx]     <= dispatch_imm;
                    e_pc[free_idx]      <= dispatch_pc;
                    e_shamt[free_idx]   <= dispatch_shamt;
                    e_rd[free_idx]      <= dispatch_rd_robnum;
                    e_rs1_rdy[free_idx] <= disp_rs1_rdy;
                    e_rs1_val[free_idx] <= disp_rs1_val;
                    e_rs1_tag[free_idx] <= dispatch_rs1_tag;
                    e_rs2_rdy[free_idx] <= disp_rs2_rdy;
                    e_rs2_val[free_idx] <= disp_rs2_val;
                    e_rs2_tag[free_idx] <= dispatch_rs2_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - directed self-checking bench for alu_issue_queue
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic              has_misbranch;
    logic              dispatch_valid;
    logic [OP_W-1:0]   dispatch_op;
    logic [DATA_W-1:0] dispatch_imm;
    logic [31:0]       dispatch_pc;
    logic [4:0]        dispatch_shamt;
    logic [ROB_W-1:0]  dispatch_rd_robnum;
    logic              dispatch_rs1_ready;
    logic              dispatch_rs2_ready;
    logic [DATA_W-1:0] dispatch_rs1_val;
    logic [DATA_W-1:0] dispatch_rs2_val;
    logic [ROB_W-1:0]  dispatch_rs1_tag;
    logic [ROB_W-1:0]  dispatch_rs2_tag;
    logic              rs_full;
    logic              cdb_alu_valid;
    logic              cdb_lsb_valid;
    logic [ROB_W-1:0]  cdb_alu_robnum;
    logic [ROB_W-1:0]  cdb_lsb_robnum;
    logic [DATA_W-1:0] cdb_alu_data;
    logic [DATA_W-1:0] cdb_lsb_data;
    logic              has_to_alu;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_imm;
    logic [31:0]       alu_pc;
    logic [4:0]        alu_shamt;
    logic [ROB_W-1:0]  alu_rd_robnum;
    logic [DATA_W-1:0] alu_rs1_oprand;
    logic [DATA_W-1:0] alu_rs2_oprand;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int r1_rdy; int r1_val; int r1_tag;
        int r2_rdy; int r2_val; int r2_tag;
        int a_v;    int a_tag;  int a_data;
        int l_v;    int l_tag;  int l_data;
        int exp_issue; int exp1; int exp2;
    } vec_t;

    vec_t vecs [9];

    alu_issue_queue dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdy                (rdy),
        .has_misbranch      (has_misbranch),
        .dispatch_valid     (dispatch_valid),
        .dispatch_op        (dispatch_op),
        .dispatch_imm       (dispatch_imm),
        .dispatch_pc        (dispatch_pc),
        .dispatch_shamt     (dispatch_shamt),
        .dispatch_rd_robnum (dispatch_rd_robnum),
        .dispatch_rs1_ready (dispatch_rs1_ready),
        .dispatch_rs2_ready (dispatch_rs2_ready),
        .dispatch_rs1_val   (dispatch_rs1_val),
        .dispatch_rs2_val   (dispatch_rs2_val),
        .dispatch_rs1_tag   (dispatch_rs1_tag),
        .dispatch_rs2_tag   (dispatch_rs2_tag),
        .rs_full            (rs_full),
        .cdb_alu_valid      (cdb_alu_valid),
        .cdb_lsb_valid      (cdb_lsb_valid),
        .cdb_alu_robnum     (cdb_alu_robnum),
        .cdb_lsb_robnum     (cdb_lsb_robnum),
        .cdb_alu_data       (cdb_alu_data),
        .cdb_lsb_data       (cdb_lsb_data),
        .has_to_alu         (has_to_alu),
        .alu_op             (alu_op),
        .alu_imm            (alu_imm),
        .alu_pc             (alu_pc),
        .alu_shamt          (alu_shamt),
        .alu_rd_robnum      (alu_rd_robnum),
        .alu_rs1_oprand     (alu_rs1_oprand),
        .alu_rs2_oprand     (alu_rs2_oprand)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy                = 1'b1;
        has_misbranch      = 1'b0;
        dispatch_valid     = 1'b0;
        dispatch_op        = '0;
        dispatch_imm       = '0;
        dispatch_pc        = '0;
        dispatch_shamt     = '0;
        dispatch_rd_robnum = '0;
        dispatch_rs1_ready = 1'b0;
        dispatch_rs2_ready = 1'b0;
        dispatch_rs1_val   = '0;
        dispatch_rs2_val   = '0;
        dispatch_rs1_tag   = '0;
        dispatch_rs2_tag   = '0;
        cdb_alu_valid      = 1'b0;
        cdb_lsb_valid      = 1'b0;
        cdb_alu_robnum     = '0;
        cdb_lsb_robnum     = '0;
        cdb_alu_data       = '0;
        cdb_lsb_data       = '0;
    endtask

    task automatic put_op(input int rd, input int imm,
                          input int r1r, input int r1v, input int r1t,
                          input int r2r, input int r2v, input int r2t);
        dispatch_valid     = 1'b1;
        dispatch_op        = OP_W'(rd + 1);
        dispatch_imm       = DATA_W'(imm);
        dispatch_pc        = 32'(32'h400 + rd * 4);
        dispatch_shamt     = 5'(rd);
        dispatch_rd_robnum = ROB_W'(rd);
        dispatch_rs1_ready = (r1r != 0);
        dispatch_rs1_val   = DATA_W'(r1v);
        dispatch_rs1_tag   = ROB_W'(r1t);
        dispatch_rs2_ready = (r2r != 0);
        dispatch_rs2_val   = DATA_W'(r2v);
        dispatch_rs2_tag   = ROB_W'(r2t);
    endtask

    task automatic cdb_alu(input int tag, input int data);
        cdb_alu_valid  = 1'b1;
        cdb_alu_robnum = ROB_W'(tag);
        cdb_alu_data   = DATA_W'(data);
    endtask

    // dispatcher must never offer an op while the queue reports full
    always @(negedge clk) begin
        if (rst_n && rdy && !has_misbranch && dispatch_valid && rs_full) begin
            failures++;
            $display("FAIL dispatch_while_full actual=1 expected=0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 5, 0,      1, 7, 0,      0, 0, 0,        0, 0, 0,        1, 5, 7};
        vecs[1] = '{0, 0, 3,      1, 2, 0,      1, 3, 'h11,     0, 0, 0,        1, 'h11, 2};
        vecs[2] = '{1, 'h100, 0,  0, 0, 4,      0, 0, 0,        1, 4, 'h22,     1, 'h100, 'h22};
        vecs[3] = '{0, 0, 6,      0, 0, 6,      1, 6, 'h33,     0, 0, 0,        1, 'h33, 'h33};
        vecs[4] = '{0, 0, 7,      1, 1, 0,      1, 7, 'h44,     1, 7, 'h55,     1, 'h44, 1};
        vecs[5] = '{0, 0, 8,      0, 0, 10,     1, 10, 'h66,    1, 8, 'h77,     1, 'h77, 'h66};
        vecs[6] = '{0, 0, 2,      1, 1, 0,      1, 3, 'h88,     1, 1, 'h99,     0, 0, 0};
        vecs[7] = '{1, 9, 5,      1, 3, 0,      1, 5, 'hEE,     0, 0, 0,        1, 9, 3};
        vecs[8] = '{0, 0, 11,     1, 4, 0,      0, 11, 'hCC,    0, 0, 0,        0, 0, 0};

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        check("reset_has_to_alu", 64'(has_to_alu), 64'd0);
        check("reset_rs_full", 64'(rs_full), 64'd0);
        check("reset_rs1_oprand", 64'(alu_rs1_oprand), 64'd0);
        check("reset_pc", 64'(alu_pc), 64'd0);
        rst_n = 1'b1;
        step();

        // single-op vectors: dispatch with optional same-cycle broadcast, then observe issue
        for (int i = 0; i < 9; i++) begin
            put_op(i, 32'h1000 + i, vecs[i].r1_rdy, vecs[i].r1_val, vecs[i].r1_tag,
                   vecs[i].r2_rdy, vecs[i].r2_val, vecs[i].r2_tag);
            cdb_alu_valid  = (vecs[i].a_v != 0);
            cdb_alu_robnum = ROB_W'(vecs[i].a_tag);
            cdb_alu_data   = DATA_W'(vecs[i].a_data);
            cdb_lsb_valid  = (vecs[i].l_v != 0);
            cdb_lsb_robnum = ROB_W'(vecs[i].l_tag);
            cdb_lsb_data   = DATA_W'(vecs[i].l_data);
            step();
            idle_inputs();
            check($sformatf("v%0d_no_issue_at_dispatch", i), 64'(has_to_alu), 64'd0);
            step();
            check($sformatf("v%0d_has_to_alu", i), 64'(has_to_alu), 64'(vecs[i].exp_issue));
            if (vecs[i].exp_issue != 0) begin
                check($sformatf("v%0d_rs1", i), 64'(alu_rs1_oprand), 64'(vecs[i].exp1));
                check($sformatf("v%0d_rs2", i), 64'(alu_rs2_oprand), 64'(vecs[i].exp2));
                check($sformatf("v%0d_rd", i), 64'(alu_rd_robnum), 64'(i));
                check($sformatf("v%0d_op", i), 64'(alu_op), 64'(i + 1));
                check($sformatf("v%0d_imm", i), 64'(alu_imm), 64'(32'h1000 + i));
                check($sformatf("v%0d_pc", i), 64'(alu_pc), 64'(32'h400 + i * 4));
                check($sformatf("v%0d_shamt", i), 64'(alu_shamt), 64'(i));
            end
            step();
            check($sformatf("v%0d_idle_after", i), 64'(has_to_alu), 64'd0);
            if (vecs[i].exp_issue == 0) begin
                has_misbranch = 1'b1;
                step();
                has_misbranch = 1'b0;
            end
        end

        // asynchronous reset between edges with entries pending and an issue on the outputs
        put_op(1, 0, 0, 0, 15, 1, 0, 0);
        step();
        put_op(2, 0, 0, 0, 15, 1, 0, 0);
        step();
        put_op(3, 0, 1, 1, 0, 1, 2, 0);
        step();
        idle_inputs();
        step();
        check("mr_issue_before_reset", 64'(has_to_alu), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("mr_has_to_alu", 64'(has_to_alu), 64'd0);
        check("mr_rs_full", 64'(rs_full), 64'd0);
        check("mr_rd", 64'(alu_rd_robnum), 64'd0);
        #1 rst_n = 1'b1;

        // fill all entries waiting on tag 15, then drain with one broadcast
        for (int k = 0; k < RS_SIZE; k++) begin
            put_op(k, 32'h200 + k, 0, 0, 15, 1, k, 0);
            step();
            check($sformatf("full_after_%0d", k), 64'(rs_full), 64'(k == RS_SIZE - 1));
        end
        idle_inputs();
        cdb_alu(15, 'h55);
        step();
        idle_inputs();
        check("full_wake_rs_full", 64'(rs_full), 64'd1);
        check("full_wake_no_issue", 64'(has_to_alu), 64'd0);
        for (int k = 0; k < RS_SIZE; k++) begin
            step();
            check($sformatf("drain%0d_valid", k), 64'(has_to_alu), 64'd1);
            check($sformatf("drain%0d_rs1", k), 64'(alu_rs1_oprand), 64'h55);
            check($sformatf("drain%0d_rs2", k), 64'(alu_rs2_oprand), 64'(k));
            check($sformatf("drain%0d_rd", k), 64'(alu_rd_robnum), 64'(k));
            if (k == 0)
                check("drain_rs_full_drops", 64'(rs_full), 64'd0);
        end
        step();
        check("drain_done", 64'(has_to_alu), 64'd0);

        // wakeup from the LSB bus alone
        put_op(9, 0, 0, 0, 9, 1, 3, 0);
        step();
        idle_inputs();
        step();
        check("lsb_wait1", 64'(has_to_alu), 64'd0);
        step();
        check("lsb_wait2", 64'(has_to_alu), 64'd0);
        cdb_lsb_valid  = 1'b1;
        cdb_lsb_robnum = 4'd9;
        cdb_lsb_data   = 32'hAB;
        step();
        idle_inputs();
        check("lsb_wake_edge", 64'(has_to_alu), 64'd0);
        step();
        check("lsb_issue", 64'(has_to_alu), 64'd1);
        check("lsb_rs1", 64'(alu_rs1_oprand), 64'hAB);
        check("lsb_rd", 64'(alu_rd_robnum), 64'd9);

        // entries 0 and 2 ready together: lowest index first, back to back
        put_op(1, 'hA0, 0, 0, 5, 1, 0, 0);
        step();
        put_op(2, 'hB0, 0, 0, 6, 1, 0, 0);
        step();
        put_op(3, 'hC0, 0, 0, 5, 1, 0, 0);
        step();
        idle_inputs();
        cdb_alu(5, 'h77);
        step();
        idle_inputs();
        step();
        check("prio_first_valid", 64'(has_to_alu), 64'd1);
        check("prio_first_rd", 64'(alu_rd_robnum), 64'd1);
        step();
        check("prio_second_valid", 64'(has_to_alu), 64'd1);
        check("prio_second_rd", 64'(alu_rd_robnum), 64'd3);
        check("prio_second_imm", 64'(alu_imm), 64'hC0);
        step();
        check("prio_done", 64'(has_to_alu), 64'd0);
        check("prio_payload_hold", 64'(alu_rd_robnum), 64'd3);
        has_misbranch = 1'b1;
        step();
        has_misbranch = 1'b0;

        // freeze with rdy low, then flush with a dispatch and broadcast in the same cycle
        for (int k = 4; k < 8; k++) begin
            put_op(k, 0, 0, 0, 12, 1, 0, 0);
            step();
        end
        put_op(8, 0, 1, 'h5A, 0, 1, 'hA5, 0);
        step();
        idle_inputs();
        step();
        check("frz_issue", 64'(has_to_alu), 64'd1);
        check("frz_issue_rd", 64'(alu_rd_robnum), 64'd8);
        rdy = 1'b0;
        put_op(10, 0, 1, 1, 0, 1, 1, 0);
        cdb_alu(12, 'h12);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("frz%0d_valid", k), 64'(has_to_alu), 64'd1);
            check($sformatf("frz%0d_rd", k), 64'(alu_rd_robnum), 64'd8);
            check($sformatf("frz%0d_rs1", k), 64'(alu_rs1_oprand), 64'h5A);
        end
        rdy = 1'b1;
        has_misbranch = 1'b1;
        step();
        idle_inputs();
        check("flush_has_to_alu", 64'(has_to_alu), 64'd0);
        check("flush_rs_full", 64'(rs_full), 64'd0);
        step();
        check("flush_discard1", 64'(has_to_alu), 64'd0);
        step();
        check("flush_discard2", 64'(has_to_alu), 64'd0);
        cdb_alu(12, 'h12);
        step();
        idle_inputs();
        step();
        check("flush_no_stale1", 64'(has_to_alu), 64'd0);
        step();
        check("flush_no_stale2", 64'(has_to_alu), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station and issue scheduler in front of the integer ALU.
- Buffers dispatched ALU/branch/jump ops until both operands are valid, capturing operands from two result broadcast buses (ALU, LSB).
- Issues at most one ready op per cycle to the ALU via a registered valid/payload.
- Flushes entirely on branch misprediction.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2)
- ROB_W, 4, ROB tag width
- DATA_W, 32, operand/data width
- OP_W, 6, internal op-code width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low freezes all state and outputs
- has_misbranch  in  1  flush request
- dispatch_valid  in  1  new op presented this cycle
- dispatch_op  in  OP_W  op code
- dispatch_imm  in  DATA_W  immediate
- dispatch_pc  in  32  instruction PC
- dispatch_shamt  in  5  shift amount
- dispatch_rd_robnum  in  ROB_W  destination ROB tag
- dispatch_rs1_ready, dispatch_rs2_ready  in  1 each  operand already valid
- dispatch_rs1_val, dispatch_rs2_val  in  DATA_W each  operand value when ready
- dispatch_rs1_tag, dispatch_rs2_tag  in  ROB_W each  producer tag when not ready
- rs_full  out  1  no free entry; combinational from registered occupancy
- cdb_alu_valid, cdb_lsb_valid  in  1 each  broadcast valid
- cdb_alu_robnum, cdb_lsb_robnum  in  ROB_W each  broadcast tag
- cdb_alu_data, cdb_lsb_data  in  DATA_W each  broadcast value
- has_to_alu  out  1  issue valid, registered
- alu_op, alu_imm, alu_pc, alu_shamt, alu_rd_robnum, alu_rs1_oprand, alu_rs2_oprand  out  match dispatch widths  issued payload, registered

Behaviour:
- Reset (rst_n=0, async): all entry valid bits 0; has_to_alu=0; payload outputs 0; rs_full=0.
- Entry state: valid, op, imm, pc, shamt, rd tag, per-operand ready/value/tag.
- rdy=0: no state change; outputs hold.
- Flush (rdy=1, has_misbranch=1):
  - All valid bits cleared and has_to_alu=0 at the edge.
  - Same-cycle dispatch and CDB inputs are ignored.
  - Flush has priority over everything.
- Dispatch (rdy=1, no flush, dispatch_valid=1, rs_full=0):
  - Write into the lowest-index free entry.
  - If dispatch_valid=1 while rs_full=1, the op is dropped (dispatcher protocol violation); the bench asserts this never happens.
- Dispatch bypass: for each not-ready operand, if a CDB valid with a matching tag occurs in the same cycle, capture the CDB data and mark the operand ready. If both CDBs match, ALU bus wins.
- Wakeup: every valid entry with a not-ready operand whose tag matches a valid CDB captures the data that edge (ALU bus wins on dual match). Both operands may wake in the same cycle.
- Select: among entries valid with both operands ready at cycle start, pick the lowest index (fixed priority).
  - Selected entry's payload goes to the outputs at the edge with has_to_alu=1; the entry is freed at the same edge.
  - No ready entry: has_to_alu=0 next cycle; payload outputs hold.
- Latency:
  - A dispatch with both operands ready at cycle N can issue at edge N+1 (visible on outputs in cycle N+2).
  - A CDB wakeup at cycle N is issuable the same way, one cycle later.
  - A newly dispatched entry is never selected in its dispatch cycle.
- A freed entry is reusable by dispatch on the following cycle. Issue and dispatch in one cycle while full: rs_full is still 1 that cycle, so dispatch stalls.
- rs_full = all RS_SIZE valid bits set.
- Ops needing only rs1 or no operand (lui, auipc, jal, immediates) are dispatched with the unused operand marked ready; the queue does not decode op.

Decomposition:
- Shared package/config include: RS_SIZE, ROB_W, DATA_W, OP_W, and True/False/Zero_Data constants; op encodings are unchanged and not referenced here.
- One natural sub-module: prio_sel, a parameterised lowest-index one-hot/encoded selector, used twice (free-slot find, ready-entry pick).

Test Plan:
- Reset mid-run: fill 3 entries, pull rst_n low asynchronously between edges -> has_to_alu=0 and rs_full=0 immediately; next dispatch lands in entry 0.
- Ready dispatch: add, rs1=5, rs2=7, both ready at cycle 0 -> cycle 2 has_to_alu=1, rs1_oprand=5, rs2_oprand=7, rd_robnum matches; cycle 3 has_to_alu=0.
- Wakeup and bypass:
  - Dispatch with rs1 waiting on tag 3 while cdb_alu tag 3 data 0x11 arrives the same cycle -> captured, issues with rs1_oprand=0x11.
  - Separate entry waiting on tag 9, woken by cdb_lsb data 0xAB at cycle N -> issues at edge N+1.
- Priority/ordering: entries 0 and 2 ready together -> entry 0 issues first, entry 2 the next cycle; back-to-back has_to_alu=1.
- Full: dispatch 8 ops waiting on tag 15 -> rs_full=1. Broadcast tag 15 -> one issue per cycle for 8 cycles; rs_full drops one cycle after the first issue.
- Flush and rdy: with 4 pending, hold rdy=0 for 3 cycles -> outputs frozen. Then has_misbranch=1 with dispatch_valid=1 -> queue empty, has_to_alu=0, dispatched op discarded.
